// File: rtl/ecg_sample_writer.sv
// ecg_sample_writer: producer side of the ECG display RAM.
// It accepts 12-bit samples over a valid/ready handshake and averages each
// group of 2^LOG2_DECIM samples. Every average goes into a circular buffer of
// BUF_LEN words that starts at BASE_ADDR. After reset, or on clear_req, the
// buffer is first filled with a flat baseline.
module ecg_sample_writer #(
  parameter logic [11:0] BASE_ADDR   = 12'h801,
  parameter int          BUF_LEN     = 640,
  parameter int          LOG2_DECIM  = 2,
  parameter logic [11:0] CLEAR_VALUE = 12'h800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        freeze,
  input  logic        clear_req,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [9:0]  wr_ptr,
  output logic        wrap,
  output logic        busy
);

  // The accumulator is wide enough to hold a full group of 12-bit samples.
  localparam int ACC_W = 12 + LOG2_DECIM;
  // The group counter keeps at least one bit, so LOG2_DECIM=0 stays legal.
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);
  localparam logic [9:0]       LAST_IDX = 10'(BUF_LEN - 1);

  // Reject a buffer that does not fit the 10-bit index or the 12-bit address space.
  generate
    if (BUF_LEN < 1 || BUF_LEN > 1024 || LOG2_DECIM < 0 ||
        (int'(BASE_ADDR) + BUF_LEN - 1) > 4095) begin : g_bad_params
      $error("ecg_sample_writer: buffer does not fit the address space");
    end
  endgenerate

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [9:0]        idx, idx_next;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ram_we_next;
  logic [11:0]       ram_addr_next;
  logic [31:0]       ram_wdata_next;
  logic [9:0]        wr_ptr_next;
  logic              wrap_next;
  logic              busy_next;
  logic [ACC_W-1:0]  sum;
  logic [11:0]       avg;
  logic              accept;

  // A clear request blocks the handshake, so a sample offered with it is never taken.
  assign sample_ready = (state != CLEAR) && !clear_req;
  assign accept       = sample_valid && sample_ready;

  // Next-state and next-output logic. clear_req overrides everything else.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    acc_next       = acc;
    cnt_next       = cnt;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr;
    ram_wdata_next = ram_wdata;
    wr_ptr_next    = wr_ptr;
    wrap_next      = 1'b0;
    busy_next      = busy;
    sum            = acc + ACC_W'(sample_data);
    avg            = 12'(sum >> LOG2_DECIM);

    if (clear_req) begin
      state_next  = CLEAR;
      idx_next    = '0;
      acc_next    = '0;
      cnt_next    = '0;
      wr_ptr_next = '0;
      busy_next   = 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ram_we_next    = 1'b1;
          ram_addr_next  = BASE_ADDR + {2'b00, idx};
          ram_wdata_next = {20'b0, CLEAR_VALUE};
          idx_next       = idx + 10'd1;
          if (idx == LAST_IDX) begin
            // freeze is sampled only when the fill finishes.
            state_next  = freeze ? FROZEN : RUN;
            idx_next    = '0;
            wr_ptr_next = '0;
            busy_next   = 1'b0;
          end
        end
        RUN: begin
          if (freeze) begin
            // Drop the partial group so that a later unfreeze starts clean.
            state_next = FROZEN;
            acc_next   = '0;
            cnt_next   = '0;
          end else if (accept) begin
            if (cnt == CNT_LAST) begin
              ram_we_next    = 1'b1;
              ram_addr_next  = BASE_ADDR + {2'b00, wr_ptr};
              ram_wdata_next = {20'b0, avg};
              wrap_next      = (wr_ptr == LAST_IDX);
              wr_ptr_next    = (wr_ptr == LAST_IDX) ? 10'd0 : wr_ptr + 10'd1;
              acc_next       = '0;
              cnt_next       = '0;
            end else begin
              acc_next = sum;
              cnt_next = cnt + CNT_W'(1);
            end
          end
        end
        FROZEN: begin
          // Accepted samples are simply dropped; the accumulator stays empty.
          acc_next = '0;
          cnt_next = '0;
          if (!freeze) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = CLEAR;
          idx_next   = '0;
          busy_next  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; an asynchronous reset restarts the baseline fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      idx       <= '0;
      acc       <= '0;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= BASE_ADDR;
      ram_wdata <= '0;
      wr_ptr    <= '0;
      wrap      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      ram_we    <= ram_we_next;
      ram_addr  <= ram_addr_next;
      ram_wdata <= ram_wdata_next;
      wr_ptr    <= wr_ptr_next;
      wrap      <= wrap_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Bench for ecg_sample_writer. It drives two instances from the same inputs:
// one averages groups of 4 samples and the other stores every sample. Each RAM
// write is logged at the falling clock edge and checked against values worked
// out by hand.
module tb_ecg_sample_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        freeze;
  logic        clear_req;

  logic        ready2, we2, wrap2, busy2;
  logic [11:0] addr2;
  logic [31:0] wdata2;
  logic [9:0]  ptr2;
  logic        ready0, we0, wrap0, busy0;
  logic [11:0] addr0;
  logic [31:0] wdata0;
  logic [9:0]  ptr0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
    logic        wrap;
    logic        busy;
  } wr_t;

  wr_t q2[$];
  wr_t q0[$];

  typedef struct {
    logic [11:0] s0, s1, s2, s3;
    logic [11:0] avg;
  } vec_t;

  vec_t tbl[8];
  int   acc_cyc[8];

  ecg_sample_writer #(.BASE_ADDR(12'h801), .BUF_LEN(640), .LOG2_DECIM(2), .CLEAR_VALUE(12'h800)) dut2 (
    .clock(clk), .reset(rst), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(ready2), .freeze(freeze), .clear_req(clear_req), .ram_we(we2),
    .ram_addr(addr2), .ram_wdata(wdata2), .wr_ptr(ptr2), .wrap(wrap2), .busy(busy2));

  ecg_sample_writer #(.BASE_ADDR(12'h801), .BUF_LEN(640), .LOG2_DECIM(0), .CLEAR_VALUE(12'h800)) dut0 (
    .clock(clk), .reset(rst), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(ready0), .freeze(freeze), .clear_req(clear_req), .ram_we(we0),
    .ram_addr(addr0), .ram_wdata(wdata0), .wr_ptr(ptr0), .wrap(wrap0), .busy(busy0));

  always #5 clk = ~clk;

  // Count rising edges so each logged write can be placed in time.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every write of both instances away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (we2) begin
      e.cyc = cyc; e.addr = addr2; e.data = wdata2; e.wrap = wrap2; e.busy = busy2;
      q2.push_back(e);
    end
    if (we0) begin
      e.cyc = cyc; e.addr = addr0; e.data = wdata0; e.wrap = wrap0; e.busy = busy0;
      q0.push_back(e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic send(input logic [11:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
  endtask

  initial begin
    int errs;
    int ec;

    rst = 1'b1; sample_data = '0; sample_valid = 1'b0; freeze = 1'b0; clear_req = 1'b0;

    // Averaging vectors: 4 samples, then the truncated mean.
    tbl[0] = '{12'd100,  12'd101,  12'd102,  12'd103,  12'd101};
    tbl[1] = '{12'd0,    12'd0,    12'd0,    12'd3,    12'd0};
    tbl[2] = '{12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
    tbl[3] = '{12'd1,    12'd2,    12'd3,    12'd5,    12'd2};
    tbl[4] = '{12'd4095, 12'd4095, 12'd4095, 12'd4094, 12'd4094};
    tbl[5] = '{12'd0,    12'd4095, 12'd0,    12'd4095, 12'd2047};
    tbl[6] = '{12'd7,    12'd7,    12'd7,    12'd6,    12'd6};
    tbl[7] = '{12'd2048, 12'd2048, 12'd2047, 12'd2047, 12'd2047};

    // Reset state.
    #1;
    chk("rst_we", we2, 0);
    chk("rst_addr", addr2, 12'h801);
    chk("rst_wdata", wdata2, 0);
    chk("rst_ptr", ptr2, 0);
    chk("rst_wrap", wrap2, 0);
    chk("rst_busy", busy2, 1);
    chk("rst_ready", ready2, 0);
    tick(); tick();
    rst = 1'b0;

    // Baseline fill after reset release.
    q2.delete(); q0.delete();
    repeat (100) tick();
    chk("fill_busy_mid", busy2, 1);
    repeat (560) tick();
    chk("fill_count", q2.size(), 640);
    errs = 0;
    for (int k = 0; k < q2.size(); k++) begin
      if (q2[k].addr !== 12'(12'h801 + k) || q2[k].data !== 32'h800 || q2[k].wrap !== 1'b0 ||
          q2[k].cyc != q2[0].cyc + k || (k < 639 && q2[k].busy !== 1'b1)) errs++;
    end
    chk("fill_entries_bad", errs, 0);
    chk("fill_count_d0", q0.size(), 640);
    chk("fill_busy_end", busy2, 0);
    chk("fill_ready_end", ready2, 1);
    chk("fill_ptr_end", ptr2, 0);

    // Averaged groups, back to back.
    q2.delete();
    for (int g = 0; g < 8; g++) begin
      send(tbl[g].s0); send(tbl[g].s1); send(tbl[g].s2); send(tbl[g].s3);
      acc_cyc[g] = cyc;
    end
    sample_valid = 1'b0;
    tick(); tick();
    chk("avg_count", q2.size(), 8);
    for (int g = 0; g < 8; g++) begin
      if (g < q2.size()) begin
        chk($sformatf("avg%0d_addr", g), q2[g].addr, 12'(12'h801 + g));
        chk($sformatf("avg%0d_data", g), q2[g].data, {20'b0, tbl[g].avg});
        chk($sformatf("avg%0d_lat", g), q2[g].cyc, acc_cyc[g]);
      end
    end
    chk("avg_ptr", ptr2, 8);

    // Restart the fill and then stream 645 samples through the instance that stores every sample.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (645) tick();
    chk("refill_busy", busy0, 0);
    q0.delete();
    for (int k = 0; k < 645; k++) send(12'(k));
    sample_valid = 1'b0;
    tick(); tick();
    chk("d0_count", q0.size(), 645);
    errs = 0;
    for (int k = 0; k < q0.size(); k++) begin
      if (q0[k].addr !== 12'(12'h801 + (k % 640)) || q0[k].data !== 32'(k) ||
          q0[k].wrap !== (k == 639)) errs++;
    end
    chk("d0_entries_bad", errs, 0);
    if (q0.size() > 640) begin
      chk("d0_wrap639", q0[639].wrap, 1);
      chk("d0_addr639", q0[639].addr, 12'hA80);
      chk("d0_addr640", q0[640].addr, 12'h801);
    end
    chk("d0_ptr", ptr0, 5);

    // Freeze: 161 groups are done and one sample is left over, then two more arrive before freezing.
    chk("pre_freeze_ptr", ptr2, 161);
    q2.delete();
    send(12'd1); send(12'd1);
    sample_valid = 1'b0;
    freeze = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) chk("frozen_ready", ready2, 1);
      send(12'h123);
    end
    sample_valid = 1'b0;
    tick();
    chk("frozen_writes", q2.size(), 0);
    chk("frozen_ptr", ptr2, 161);
    freeze = 1'b0;
    tick();
    send(12'hFFF); send(12'hFFF); send(12'hFFF); send(12'hFFF);
    ec = cyc;
    sample_valid = 1'b0;
    tick(); tick();
    chk("unfreeze_count", q2.size(), 1);
    if (q2.size() > 0) begin
      chk("unfreeze_addr", q2[0].addr, 12'h8A2);
      chk("unfreeze_data", q2[0].data, 32'hFFF);
      chk("unfreeze_lat", q2[0].cyc, ec);
    end
    chk("unfreeze_ptr", ptr2, 162);

    // clear_req arrives together with the sample that would complete a group.
    q2.delete();
    send(12'd5); send(12'd5); send(12'd5);
    sample_data = 12'd5; sample_valid = 1'b1; clear_req = 1'b1;
    #1;
    chk("clr_ready", ready2, 0);
    tick();
    clear_req = 1'b0; sample_valid = 1'b0;
    chk("clr_ptr", ptr2, 0);
    chk("clr_busy", busy2, 1);
    tick(); tick(); tick();
    chk("clr_any_write", q2.size() > 0, 1);
    if (q2.size() > 0) begin
      chk("clr_first_addr", q2[0].addr, 12'h801);
      chk("clr_first_data", q2[0].data, 32'h800);
    end

    // Asynchronous reset in the middle of the fill.
    for (int i = 0; i < 1000 && addr2 != 12'h92D; i++) tick();
    chk("mid_clear_addr", addr2, 12'h92D);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", we2, 0);
    chk("arst_addr", addr2, 12'h801);
    chk("arst_wdata", wdata2, 0);
    chk("arst_busy", busy2, 1);
    chk("arst_ptr", ptr2, 0);
    tick(); tick();
    rst = 1'b0;
    q2.delete();
    repeat (645) tick();
    chk("rerun_count", q2.size(), 640);
    if (q2.size() == 640) begin
      chk("rerun_first", q2[0].addr, 12'h801);
      chk("rerun_last", q2[639].addr, 12'hA80);
    end
    chk("rerun_busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stop a run that never ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
